// File: rtl/squash_input_conditioner.sv
// Pushbutton conditioner: 2-flop synchroniser, counter debouncer and press/release pulses per channel.
// Define SQUASH_INPUT_AUTOREPEAT_EN to add auto-repeat press pulses on REPEAT_MASK channels.
module squash_input_conditioner #(
    parameter int unsigned          N_INPUTS        = 4,
    parameter int unsigned          DEBOUNCE_W      = 16,
    parameter int unsigned          DEBOUNCE_CYCLES = 25000,
    parameter int unsigned          REPEAT_DELAY    = 250000,
    parameter int unsigned          REPEAT_PERIOD   = 100000,
    parameter logic [N_INPUTS-1:0]  REPEAT_MASK     = 4'b1100
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_INPUTS-1:0] btn_n_i,
    output logic [N_INPUTS-1:0] btn_o,
    output logic [N_INPUTS-1:0] btn_press_o,
    output logic [N_INPUTS-1:0] btn_release_o
);

    localparam logic [DEBOUNCE_W-1:0] CntMax = DEBOUNCE_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DEBOUNCE_W-1:0] CntOne = DEBOUNCE_W'(1);

    logic [N_INPUTS-1:0]                 sync1_q, sync1_d;
    logic [N_INPUTS-1:0]                 sync2_q, sync2_d;
    logic [N_INPUTS-1:0][DEBOUNCE_W-1:0] cnt_q, cnt_d;
    logic [N_INPUTS-1:0]                 btn_q, btn_d;
    logic [N_INPUTS-1:0]                 press_q, press_d;
    logic [N_INPUTS-1:0]                 release_q, release_d;

    logic [N_INPUTS-1:0] pressed_s;
    logic [N_INPUTS-1:0] accept_press;
    logic [N_INPUTS-1:0] accept_release;

    assign pressed_s = ~sync2_q;

    always_comb begin
        sync1_d        = btn_n_i;
        sync2_d        = sync1_q;
        cnt_d          = cnt_q;
        btn_d          = btn_q;
        accept_press   = '0;
        accept_release = '0;
        for (int i = 0; i < int'(N_INPUTS); i++) begin
            if (pressed_s[i] == btn_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CntMax) begin
                btn_d[i]          = pressed_s[i];
                cnt_d[i]          = '0;
                accept_press[i]   = pressed_s[i];
                accept_release[i] = ~pressed_s[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CntOne;
            end
        end
    end

`ifdef SQUASH_INPUT_AUTOREPEAT_EN
    localparam int unsigned    RepW      = $clog2(REPEAT_DELAY + 1);
    localparam logic [RepW-1:0] RepMax    = RepW'(REPEAT_DELAY - 1);
    localparam logic [RepW-1:0] RepReload = RepW'(REPEAT_DELAY - REPEAT_PERIOD);
    localparam logic [RepW-1:0] RepOne    = RepW'(1);

    logic [N_INPUTS-1:0][RepW-1:0] rep_q, rep_d;
    logic [N_INPUTS-1:0]           rep_fire;

    // An accepted release clears the repeat counter, so release always beats a repeat pulse.
    always_comb begin
        rep_d    = rep_q;
        rep_fire = '0;
        for (int i = 0; i < int'(N_INPUTS); i++) begin
            if (!REPEAT_MASK[i] || !btn_q[i] || accept_press[i] || accept_release[i]) begin
                rep_d[i] = '0;
            end else if (rep_q[i] == RepMax) begin
                rep_fire[i] = 1'b1;
                rep_d[i]    = RepReload;
            end else begin
                rep_d[i] = rep_q[i] + RepOne;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rep_q <= '0;
        end else begin
            rep_q <= rep_d;
        end
    end

    always_comb begin
        press_d   = accept_press | rep_fire;
        release_d = accept_release;
    end
`else
    always_comb begin
        press_d   = accept_press;
        release_d = accept_release;
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q   <= '1;
            sync2_q   <= '1;
            cnt_q     <= '0;
            btn_q     <= '0;
            press_q   <= '0;
            release_q <= '0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            cnt_q     <= cnt_d;
            btn_q     <= btn_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign btn_o         = btn_q;
    assign btn_press_o   = press_q;
    assign btn_release_o = release_q;

endmodule

// File: tb/tb_squash_input_conditioner.sv
// Directed bench for squash_input_conditioner with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5.
module tb_squash_input_conditioner;

`ifdef SQUASH_INPUT_AUTOREPEAT_EN
    localparam bit AutoRep = 1'b1;
`else
    localparam bit AutoRep = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] btn_n_i;
    logic [3:0] btn_o;
    logic [3:0] btn_press_o;
    logic [3:0] btn_release_o;

    int n_checks = 0;
    int n_fail   = 0;

    squash_input_conditioner #(
        .N_INPUTS        (4),
        .DEBOUNCE_W      (16),
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (10),
        .REPEAT_PERIOD   (5),
        .REPEAT_MASK     (4'b1100)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .btn_n_i       (btn_n_i),
        .btn_o         (btn_o),
        .btn_press_o   (btn_press_o),
        .btn_release_o (btn_release_o)
    );

    always #5 clk = ~clk;

    // Returns 1 time unit after the rising edge, so samples and new inputs sit away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [3:0] b, input logic [3:0] p,
                             input logic [3:0] r);
        check({tag, ".btn"}, btn_o, b);
        check({tag, ".press"}, btn_press_o, p);
        check({tag, ".release"}, btn_release_o, r);
    endtask

    initial begin
        logic [3:0] exp_p;
        logic [3:0] exp_b;
        logic [3:0] exp_r;
        int         since;

        // Reset and idle
        reset   = 1'b1;
        btn_n_i = 4'b1111;
        tick();
        check_all("in_reset", 4'b0000, 4'b0000, 4'b0000);
        tick();
        reset = 1'b0;
        for (int t = 0; t < 20; t++) begin
            tick();
            check_all("idle", 4'b0000, 4'b0000, 4'b0000);
        end

        // Clean press on channel 2: accepted on the 6th edge
        btn_n_i[2] = 1'b0;
        for (int t = 1; t <= 6; t++) begin
            tick();
            if (t < 6) check_all("press2_wait", 4'b0000, 4'b0000, 4'b0000);
            else       check_all("press2_acc", 4'b0100, 4'b0100, 4'b0000);
        end
        tick();
        check_all("press2_after", 4'b0100, 4'b0000, 4'b0000);

        // Bounce 1,0,1,0 at 2-cycle intervals, then a clean release
        for (int ph = 0; ph < 4; ph++) begin
            btn_n_i[2] = (ph % 2 == 0) ? 1'b1 : 1'b0;
            for (int t = 0; t < 2; t++) begin
                tick();
                check_all("bounce", 4'b0100, 4'b0000, 4'b0000);
            end
        end
        btn_n_i[2] = 1'b1;
        for (int t = 1; t <= 6; t++) begin
            tick();
            if (t < 6) check_all("rel2_wait", 4'b0100, 4'b0000, 4'b0000);
            else       check_all("rel2_acc", 4'b0000, 4'b0000, 4'b0100);
        end
        tick();
        check_all("rel2_after", 4'b0000, 4'b0000, 4'b0000);

        // Simultaneous press and release on channels 0 and 3
        btn_n_i = 4'b0110;
        for (int t = 1; t <= 6; t++) begin
            tick();
            if (t < 6) check_all("press03_wait", 4'b0000, 4'b0000, 4'b0000);
            else       check_all("press03_acc", 4'b1001, 4'b1001, 4'b0000);
        end
        btn_n_i = 4'b1111;
        for (int t = 1; t <= 6; t++) begin
            tick();
            if (t < 6) check_all("rel03_wait", 4'b1001, 4'b0000, 4'b0000);
            else       check_all("rel03_acc", 4'b0000, 4'b0000, 4'b1001);
        end

        // Reset while channel 1 is accepted and held
        btn_n_i = 4'b1101;
        for (int t = 1; t <= 6; t++) begin
            tick();
            if (t == 6) check_all("press1_acc", 4'b0010, 4'b0010, 4'b0000);
        end
        tick();
        check_all("press1_hold", 4'b0010, 4'b0000, 4'b0000);
        #2;
        reset = 1'b1;
        #1;
        check_all("async_reset", 4'b0000, 4'b0000, 4'b0000);
        for (int t = 0; t < 3; t++) begin
            tick();
            check_all("held_reset", 4'b0000, 4'b0000, 4'b0000);
        end
        reset = 1'b0;
        for (int t = 1; t <= 6; t++) begin
            tick();
            if (t < 6) check_all("repress1_wait", 4'b0000, 4'b0000, 4'b0000);
            else       check_all("repress1_acc", 4'b0010, 4'b0010, 4'b0000);
        end
        btn_n_i = 4'b1111;
        for (int t = 1; t <= 6; t++) begin
            tick();
            if (t == 6) check_all("rel1_acc", 4'b0000, 4'b0000, 4'b0010);
        end

        // Hold channels 0 and 3 for 40 cycles after acceptance; only channel 3 may repeat
        btn_n_i = 4'b0110;
        for (int t = 1; t <= 52; t++) begin
            tick();
            since = t - 6;
            exp_p = 4'b0000;
            exp_r = 4'b0000;
            exp_b = (t >= 6 && t < 52) ? 4'b1001 : 4'b0000;
            if (t == 6) exp_p = 4'b1001;
            if (AutoRep && t < 52 && since >= 10 && ((since - 10) % 5 == 0)) exp_p = 4'b1000;
            if (t == 52) exp_r = 4'b1001;
            check_all("hold03", exp_b, exp_p, exp_r);
            if (t == 46) btn_n_i = 4'b1111;
        end
        tick();
        check_all("final", 4'b0000, 4'b0000, 4'b0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
